// File: rtl/tick_pkg.sv
// Shared types and board constants for the tick-strobe monitor.
package tick_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_e;

  localparam int CLK_HZ           = 50_000_000;
  localparam int TICK_HZ          = 4;
  localparam int DEFAULT_EXPECTED = CLK_HZ / TICK_HZ;

endpackage

// File: rtl/tick_monitor_if.sv
// Strobe input and measurement results of the tick monitor, bundled as one port.
interface tick_monitor_if #(
  parameter int CW = 24
);

  logic          tick;
  logic [CW-1:0] period_out;
  logic          period_valid;
  logic          early;
  logic          late;
  logic          locked;
  logic [7:0]    miss_count;

  modport master (
    output tick,
    input  period_out, period_valid, early, late, locked, miss_count
  );

  modport slave (
    input  tick,
    output period_out, period_valid, early, late, locked, miss_count
  );

endinterface

// File: rtl/tick_monitor.sv
// Measures the spacing of a periodic one-cycle strobe, flags early/missing
// strobes and reports lock after two consecutive in-tolerance periods.
//
//   state  | meaning
//   SEARCH | waiting for a reference tick to start measuring
//   TRACK  | counting cycles since the last tick
module tick_monitor
  import tick_pkg::*;
#(
  parameter int EXPECTED = DEFAULT_EXPECTED,
  parameter int TOL      = 4,
  parameter int CW       = 24
) (
  input logic           clk,
  input logic           reset,
  tick_monitor_if.slave mon
);

  if (longint'(EXPECTED) + longint'(TOL) >= (longint'(1) << CW)) begin : g_cw_check
    $error("tick_monitor: EXPECTED+TOL does not fit in CW bits");
  end
  if (TOL >= EXPECTED) begin : g_tol_check
    $error("tick_monitor: TOL must be smaller than EXPECTED");
  end

  localparam logic [CW-1:0] LO = CW'(EXPECTED - TOL);
  localparam logic [CW-1:0] HI = CW'(EXPECTED + TOL);

  state_e        state_q;
  logic [CW-1:0] counter_q;
  logic [1:0]    good_q;
  logic [CW-1:0] period_q;
  logic          valid_q;
  logic          early_q;
  logic          late_q;
  logic          locked_q;
  logic [7:0]    miss_q;

  // counter never exceeds HI-1 in TRACK, so elapsed cannot wrap
  logic [CW-1:0] elapsed_d;
  assign elapsed_d = counter_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SEARCH;
      counter_q <= '0;
      good_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      early_q   <= 1'b0;
      late_q    <= 1'b0;
      locked_q  <= 1'b0;
      miss_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (mon.tick) begin
            counter_q <= '0;
            state_q   <= TRACK;
          end
        end
        TRACK: begin
          if (mon.tick) begin
            period_q  <= elapsed_d;
            valid_q   <= 1'b1;
            counter_q <= '0;
            if (elapsed_d >= LO) begin
              if (good_q != 2'd2) good_q <= good_q + 2'd1;
              if (good_q != 2'd0) locked_q <= 1'b1;
            end else begin
              early_q  <= 1'b1;
              good_q   <= '0;
              locked_q <= 1'b0;
            end
          end else if (elapsed_d == HI) begin
            late_q    <= 1'b1;
            if (miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
            good_q    <= '0;
            locked_q  <= 1'b0;
            counter_q <= '0;
            state_q   <= SEARCH;
          end else begin
            counter_q <= elapsed_d;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign mon.period_out   = period_q;
  assign mon.period_valid = valid_q;
  assign mon.early        = early_q;
  assign mon.late         = late_q;
  assign mon.locked       = locked_q;
  assign mon.miss_count   = miss_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Self-checking bench for tick_monitor with EXPECTED=10, TOL=1, CW=8.
module tb_tick_monitor;

  localparam int EXP = 10;
  localparam int TOL = 1;
  localparam int CW  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  tick_monitor_if #(.CW(CW)) mon();

  tick_monitor #(.EXPECTED(EXP), .TOL(TOL), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          late;
    logic [CW-1:0] period;
    logic          early;
    logic          locked;
    logic [7:0]    miss;
  } exp_t;

  exp_t sb[$];
  exp_t ev;

  typedef struct {
    int            gap;
    logic          valid;
    logic [CW-1:0] period;
    logic          early;
    logic          locked;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period_out"}, 32'(mon.period_out), 0);
    chk({tag, "_period_valid"}, 32'(mon.period_valid), 0);
    chk({tag, "_early"}, 32'(mon.early), 0);
    chk({tag, "_late"}, 32'(mon.late), 0);
    chk({tag, "_locked"}, 32'(mon.locked), 0);
    chk({tag, "_miss_count"}, 32'(mon.miss_count), 0);
  endtask

  // called right after an active edge; the tick is sampled gap edges later
  task automatic do_tick(input int gap);
    repeat (gap - 1) @(posedge clk);
    #1 mon.tick = 1'b1;
    @(posedge clk);
    #1 mon.tick = 1'b0;
  endtask

  task automatic push(input logic late, input int period, input logic early,
                      input logic locked, input int miss);
    exp_t e;
    e.late   = late;
    e.period = CW'(period);
    e.early  = early;
    e.locked = locked;
    e.miss   = 8'(miss);
    sb.push_back(e);
  endtask

  // output monitor: every period_valid/late pulse is matched against the scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon.period_valid || mon.late) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: valid=%0b late=%0b period=%0d, required no event at %0t",
                   mon.period_valid, mon.late, mon.period_out, $time);
        end else begin
          ev = sb.pop_front();
          chk("ev_late", 32'(mon.late), 32'(ev.late));
          chk("ev_valid", 32'(mon.period_valid), 32'(!ev.late));
          chk("ev_period_out", 32'(mon.period_out), 32'(ev.period));
          chk("ev_early", 32'(mon.early), 32'(ev.early));
          chk("ev_locked", 32'(mon.locked), 32'(ev.locked));
          chk("ev_miss_count", 32'(mon.miss_count), 32'(ev.miss));
        end
      end else if (mon.early) begin
        checks++;
        errors++;
        $display("FAIL stray_early: early=1 without period_valid, required 0 at %0t", $time);
      end
    end
  end

  initial begin
    int miss_exp;
    mon.tick = 1'b0;

    vecs[0]  = '{3,  1'b0, 0,  1'b0, 1'b0};
    vecs[1]  = '{10, 1'b1, 10, 1'b0, 1'b0};
    vecs[2]  = '{10, 1'b1, 10, 1'b0, 1'b1};
    vecs[3]  = '{9,  1'b1, 9,  1'b0, 1'b1};
    vecs[4]  = '{11, 1'b1, 11, 1'b0, 1'b1};
    vecs[5]  = '{8,  1'b1, 8,  1'b1, 1'b0};
    vecs[6]  = '{10, 1'b1, 10, 1'b0, 1'b0};
    vecs[7]  = '{10, 1'b1, 10, 1'b0, 1'b1};
    vecs[8]  = '{1,  1'b1, 1,  1'b1, 1'b0};
    vecs[9]  = '{1,  1'b1, 1,  1'b1, 1'b0};
    vecs[10] = '{10, 1'b1, 10, 1'b0, 1'b0};
    vecs[11] = '{10, 1'b1, 10, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    reset = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].valid) push(1'b0, int'(vecs[i].period), vecs[i].early, vecs[i].locked, 0);
      do_tick(vecs[i].gap);
    end

    // timeout while locked
    push(1'b1, 10, 1'b0, 1'b0, 1);
    repeat (11) @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #2;
    chk("timeout_drained", 32'(sb.size()), 0);
    chk("timeout_locked", 32'(mon.locked), 0);
    chk("timeout_miss", 32'(mon.miss_count), 1);

    do_tick(5);
    push(1'b0, 10, 1'b0, 1'b0, 1);
    do_tick(10);
    push(1'b0, 11, 1'b0, 1'b1, 1);
    do_tick(11);
    push(1'b0, 10, 1'b0, 1'b1, 1);
    do_tick(10);

    // saturating miss counter
    for (int i = 0; i < 256; i++) begin
      if (i > 0) do_tick(3);
      miss_exp = (i + 2 > 255) ? 255 : i + 2;
      push(1'b1, 10, 1'b0, 1'b0, miss_exp);
      repeat (11) @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #2;
    chk("sat_drained", 32'(sb.size()), 0);
    chk("sat_miss", 32'(mon.miss_count), 255);
    chk("sat_period_held", 32'(mon.period_out), 10);

    // reset mid-TRACK, then a tick coinciding with reset must be ignored
    do_tick(3);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 chk_zero("midreset");
    mon.tick = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    mon.tick = 1'b0;
    do_tick(10);
    push(1'b0, 10, 1'b0, 1'b0, 0);
    do_tick(10);
    repeat (3) @(posedge clk);
    #2;
    chk("final_drained", 32'(sb.size()), 0);
    chk("final_period", 32'(mon.period_out), 10);
    chk("final_miss", 32'(mon.miss_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
